// File: rtl/codificador_sequencial_pkg.sv
// Shared types and defaults for the sequential line-vector encoder.
package codificador_sequencial_pkg;

    localparam int N_DEF = 8;
    localparam int W_DEF = $clog2(N_DEF);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/codificador_sequencial_if.sv
// Vector-in / index-out valid/ready bundle for the encoder.
interface codificador_sequencial_if
    import codificador_sequencial_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = $clog2(N)
);
    logic [N-1:0] in_s;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_a;
    logic         out_zero;
    logic         out_last;
    logic [W:0]   out_count;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_s, in_valid, out_ready,
        input  in_ready, out_a, out_zero,
        input  out_last, out_count, out_valid
    );

    modport slave (
        input  in_s, in_valid, out_ready,
        output in_ready, out_a, out_zero,
        output out_last, out_count, out_valid
    );

endinterface

// File: rtl/codificador_sequencial_prio.sv
// Lowest-set-bit finder: index, any-set flag and one-hot mask of that bit.
module codificador_sequencial_prio #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         any_o,
    output logic [N-1:0] mask_o
);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = W'(i);
        end
    end

    assign any_o  = |vec_i;
    assign mask_o = vec_i & (~vec_i + N'(1));

endmodule

// File: rtl/codificador_sequencial.sv
// Sequential encoder: emits the index of every set line, lowest first,
// one valid/ready beat per set bit (one beat flagged zero for 0).
module codificador_sequencial
    import codificador_sequencial_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = $clog2(N)
) (
    input logic                     clk,
    input logic                     rst_n,
    codificador_sequencial_if.slave bus
);

    state_e       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W:0]   count_q, count_d;

    logic [W-1:0] lsb_idx;
    logic         lsb_any;
    logic [N-1:0] lsb_mask;
    logic         last;

    function automatic logic [W:0] popcnt(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + (W+1)'(v[i]);
        return c;
    endfunction

    codificador_sequencial_prio #(
        .N(N),
        .W(W)
    ) u_prio (
        .vec_i (pending_q),
        .idx_o (lsb_idx),
        .any_o (lsb_any),
        .mask_o(lsb_mask)
    );

    assign last = (popcnt(pending_q) <= (W+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d   = ST_EMIT;
                    pending_d = bus.in_s;
                    count_d   = popcnt(bus.in_s);
                end
            end
            ST_EMIT: begin
                // A zero vector has an empty mask, so it drains in one beat.
                if (bus.out_ready) begin
                    pending_d = pending_q & ~lsb_mask;
                    if (last) state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_EMIT);
        bus.out_a     = lsb_idx;
        bus.out_zero  = (state_q == ST_EMIT) && !lsb_any;
        bus.out_last  = (state_q == ST_EMIT) && last;
        bus.out_count = count_q;
    end

endmodule

// File: tb/tb_codificador_sequencial.sv
// Scoreboard bench for codificador_sequencial (N=8).
module tb_codificador_sequencial;

    typedef struct packed {
        logic [2:0] a;
        logic       zero;
        logic       last;
        logic [3:0] cnt;
    } beat_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    beat_t sb[$];

    codificador_sequencial_if #(.N(8)) bus ();

    codificador_sequencial #(.N(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic beat_t got();
        beat_t g;
        g.a    = bus.out_a;
        g.zero = bus.out_zero;
        g.last = bus.out_last;
        g.cnt  = bus.out_count;
        return g;
    endfunction

    // Drive one vector and push its expected beats.
    task automatic send(input logic [7:0] v);
        int    n;
        int    k;
        int    seen;
        beat_t e;
        n    = 0;
        seen = 0;
        k    = $countones(v);
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_ready: in_ready=%b want 1",
                     bus.in_ready);
        end
        if (v == 8'h00) begin
            e = '{3'd0, 1'b1, 1'b1, 4'd0};
            sb.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                seen++;
                e.a    = 3'(i);
                e.zero = 1'b0;
                e.last = (seen == k);
                e.cnt  = 4'(k);
                sb.push_back(e);
            end
        end
        bus.in_s     = v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_s      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        tests++;
        if ({bus.out_valid, bus.out_a, bus.out_count,
             bus.out_zero, bus.out_last} !== 10'd0) begin
            fails++;
            $display("FAIL reset_out: v=%b a=%0d c=%0d z=%b l=%b want 0",
                     bus.out_valid, bus.out_a, bus.out_count,
                     bus.out_zero, bus.out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_onehot();
        beat_t e;
        int    n;
        for (int v = 0; v < 8; v++) begin
            send(8'(1 << v));
            n = 0;
            while (sb.size() > 0 && n < 20) begin
                @(negedge clk);
                #1 n++;
                if (bus.out_valid && bus.out_ready) begin
                    e = sb.pop_front();
                    tests++;
                    if (got() !== e) begin
                        fails++;
                        $display("FAIL onehot: got %h want %h", got(), e);
                    end
                end
            end
            if (sb.size() > 0) begin
                tests++;
                fails++;
                $display("FAIL onehot_timeout: %0d beats left want 0",
                         sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_multihot();
        beat_t e;
        int    n;
        send(8'b1010_0110);
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            #1 n++;
            tests++;
            if (!bus.out_valid || bus.in_ready) begin
                fails++;
                $display("FAIL multihot_flow: v=%b rdy=%b want 1/0",
                         bus.out_valid, bus.in_ready);
            end else begin
                e = sb.pop_front();
                if (got() !== e) begin
                    fails++;
                    $display("FAIL multihot: got %h want %h", got(), e);
                end
            end
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL multihot_timeout: %0d left", sb.size());
            sb.delete();
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL multihot_gap: in_ready=%b out_valid=%b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_zero();
        beat_t e;
        int    n;
        send(8'h00);
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge clk);
            #1 n++;
            if (bus.out_valid && bus.out_ready) begin
                e = sb.pop_front();
                tests++;
                if (got() !== e) begin
                    fails++;
                    $display("FAIL zero: got %h want %h", got(), e);
                end
            end
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL zero_timeout: %0d left", sb.size());
            sb.delete();
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_once: out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic run_bp(input logic [7:0] v, input bit rnd);
        beat_t e;
        int    n;
        send(v);
        n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(negedge clk);
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            else     bus.out_ready = ~bus.out_ready;
            #1 n++;
            tests++;
            if (!bus.out_valid) begin
                fails++;
                $display("FAIL bp_valid: out_valid=%b want 1",
                         bus.out_valid);
            end else if (bus.out_ready) begin
                e = sb.pop_front();
                if (got() !== e) begin
                    fails++;
                    $display("FAIL bp_beat: got %h want %h", got(), e);
                end
            end else if (got() !== sb[0]) begin
                fails++;
                $display("FAIL bp_hold: got %h want %h", got(), sb[0]);
            end
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL bp_timeout: %0d left", sb.size());
            sb.delete();
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b1;
        run_bp(8'hFF, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_bp(8'($urandom_range(0, 255)), 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        beat_t e;
        int    n;
        int    popped;
        send(8'hF0);
        n      = 0;
        popped = 0;
        while (popped < 2 && n < 10) begin
            @(negedge clk);
            #1 n++;
            if (bus.out_valid && bus.out_ready) begin
                e = sb.pop_front();
                popped++;
                tests++;
                if (got() !== e) begin
                    fails++;
                    $display("FAIL mid_beat: got %h want %h", got(), e);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_a !== 3'd0 ||
            bus.out_count !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset: v=%b a=%0d c=%0d want 0/0/0",
                     bus.out_valid, bus.out_a, bus.out_count);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h08);
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge clk);
            #1 n++;
            if (bus.out_valid && bus.out_ready) begin
                e = sb.pop_front();
                tests++;
                if (got() !== e) begin
                    fails++;
                    $display("FAIL mid_after: got %h want %h", got(), e);
                end
            end
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL mid_timeout: %0d left", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_onehot();
        test_multihot();
        test_zero();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
